// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the programmable clock divider.
//   CLK_DIV_W              default counter/limit width
//   CLK_DIV_DEFAULT_LIMIT  half-period limit loaded at reset (50 MHz -> 1 kHz)
//   limit_t                limit type at the default width
//   ch_idx_w()             width of a channel index, never less than 1
package clk_div_pkg;

   localparam int unsigned CLK_DIV_W             = 16;
   localparam int unsigned CLK_DIV_DEFAULT_LIMIT = 24999;

   typedef logic [CLK_DIV_W-1:0] limit_t;

   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, active/shadow limits, apply).
// Optional feature macro: CLKDIV_DUTY_EN (separate high-phase limit).
// Ports:
//   clk_in, ar         system clock, async active-high reset
//   en                 run enable; low holds the channel in low phase, count 0
//   sync               restart in phase, apply shadow
//   wr_en              decoded, accepted write for this channel
//   wr_low, wr_high    new limits (wr_high only with CLKDIV_DUTY_EN)
//   clk_out, tick      divided output, one-cycle rise pulse
//   pending            shadow holds a limit not yet applied
module clk_div_chan #(
   parameter int unsigned W             = 16,
   parameter int unsigned DEFAULT_LIMIT = 24999
) (
   input  logic         clk_in,
   input  logic         ar,
   input  logic         en,
   input  logic         sync,
   input  logic         wr_en,
   input  logic [W-1:0] wr_low,
`ifdef CLKDIV_DUTY_EN
   input  logic [W-1:0] wr_high,
`endif
   output logic         clk_out,
   output logic         tick,
   output logic         pending
);

   localparam logic [W-1:0] RST_LIM = W'(DEFAULT_LIMIT);

   logic [W-1:0] count;
   logic [W-1:0] lim_lo;
   logic [W-1:0] sh_lo;
   logic [W-1:0] lim_act;
   logic         at_lim;
   logic         apply;

`ifdef CLKDIV_DUTY_EN
   logic [W-1:0] lim_hi;
   logic [W-1:0] sh_hi;
   assign lim_act = clk_out ? lim_hi : lim_lo;
`else
   assign lim_act = lim_lo;
`endif

   // >= rather than == so a limit lowered below the running count still ends the phase
   assign at_lim = (count >= lim_act);
   // end of a full period is the running 1->0 transition
   assign apply  = sync | ~en | (clk_out & at_lim);

   always_ff @(posedge clk_in or posedge ar) begin
      if (ar) begin
         count   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (sync || !en) begin
         count   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (at_lim) begin
         count   <= '0;
         clk_out <= ~clk_out;
         tick    <= ~clk_out;
      end else begin
         count   <= count + 1'b1;
         tick    <= 1'b0;
      end
   end

   // Shadow equals active whenever pending is low, so applying unconditionally is safe.
   // On a write coinciding with apply, the old shadow moves to active and the new data stays pending.
   always_ff @(posedge clk_in or posedge ar) begin
      if (ar) begin
         lim_lo  <= RST_LIM;
         sh_lo   <= RST_LIM;
         pending <= 1'b0;
      end else begin
         if (apply)
            lim_lo <= sh_lo;
         if (wr_en) begin
            sh_lo   <= wr_low;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef CLKDIV_DUTY_EN
   always_ff @(posedge clk_in or posedge ar) begin
      if (ar) begin
         lim_hi <= RST_LIM;
         sh_hi  <= RST_LIM;
      end else begin
         if (apply)
            lim_hi <= sh_hi;
         if (wr_en)
            sh_hi <= wr_high;
      end
   end
`endif

endmodule

// File: rtl/prog_clk_div.sv
// prog_clk_div: CH-channel runtime-programmable clock divider.
// Optional feature macro: CLKDIV_DUTY_EN (independent high/low half-periods).
// Ports:
//   clk_in, ar                    system clock, async active-high reset
//   en[CH]                        per-channel run enable
//   sync                          restart all channels in phase
//   wr_valid/wr_ready             limit write handshake (ready = not in reset)
//   wr_ch, wr_low, wr_high        target channel and new limits
//   clk_out[CH], tick[CH]         divided outputs and rise pulses
//   pending[CH]                   written limit awaiting apply
module prog_clk_div
   import clk_div_pkg::*;
#(
   parameter int unsigned CH            = 4,
   parameter int unsigned W             = CLK_DIV_W,
   parameter int unsigned DEFAULT_LIMIT = CLK_DIV_DEFAULT_LIMIT,
   localparam int unsigned CH_W         = ch_idx_w(CH)
) (
   input  logic            clk_in,
   input  logic            ar,
   input  logic [CH-1:0]   en,
   input  logic            sync,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [CH_W-1:0] wr_ch,
   input  logic [W-1:0]    wr_low,
   input  logic [W-1:0]    wr_high,
   output logic [CH-1:0]   clk_out,
   output logic [CH-1:0]   tick,
   output logic [CH-1:0]   pending
);

   logic wr_acc;

   assign wr_ready = ~ar;
   assign wr_acc   = wr_valid & wr_ready;

`ifndef CLKDIV_DUTY_EN
   logic unused_wr_high;
   assign unused_wr_high = ^wr_high;
`endif

   // An out-of-range wr_ch matches no channel, so the write is accepted and dropped.
   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic wr_hit;
      assign wr_hit = wr_acc && (wr_ch == CH_W'(i));

      clk_div_chan #(
         .W             (W),
         .DEFAULT_LIMIT (DEFAULT_LIMIT)
      ) u_chan (
         .clk_in  (clk_in),
         .ar      (ar),
         .en      (en[i]),
         .sync    (sync),
         .wr_en   (wr_hit),
         .wr_low  (wr_low),
`ifdef CLKDIV_DUTY_EN
         .wr_high (wr_high),
`endif
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;

   localparam int CH = 5;
   localparam int W  = 8;
   localparam int CW = 3;

   logic          clk_in = 1'b0;
   logic          ar;
   logic [CH-1:0] en;
   logic          sync;
   logic          wr_valid;
   logic          wr_ready;
   logic [CW-1:0] wr_ch;
   logic [W-1:0]  wr_low;
   logic [W-1:0]  wr_high;
   logic [CH-1:0] clk_out;
   logic [CH-1:0] tick;
   logic [CH-1:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   prog_clk_div #(.CH(CH), .W(W), .DEFAULT_LIMIT(3)) dut (
      .clk_in   (clk_in),
      .ar       (ar),
      .en       (en),
      .sync     (sync),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_ch    (wr_ch),
      .wr_low   (wr_low),
      .wr_high  (wr_high),
      .clk_out  (clk_out),
      .tick     (tick),
      .pending  (pending)
   );

   always #5 clk_in = ~clk_in;

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic do_write(input int ch, input int lo, input int hi);
      wr_valid = 1'b1;
      wr_ch    = CW'(ch);
      wr_low   = W'(lo);
      wr_high  = W'(hi);
      step(1);
      wr_valid = 1'b0;
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      step(1);
      sync = 1'b0;
   endtask

   task automatic test_reset();
      ar = 1'b1; en = '1; sync = 1'b0; wr_valid = 1'b0;
      wr_ch = '0; wr_low = '0; wr_high = '0;
      step(2);
      n_tests++; if (clk_out !== 5'h00) begin n_fail++; $display("FAIL rst_clk_out got %h exp 00", clk_out); end
      n_tests++; if (tick !== 5'h00) begin n_fail++; $display("FAIL rst_tick got %h exp 00", tick); end
      n_tests++; if (pending !== 5'h00) begin n_fail++; $display("FAIL rst_pending got %h exp 00", pending); end
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
      ar = 1'b0;
      step(3);
      n_tests++; if (clk_out !== 5'h00) begin n_fail++; $display("FAIL edge3_low got %h exp 00", clk_out); end
      n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL run_wr_ready got %b exp 1", wr_ready); end
      step(1);
      n_tests++; if (clk_out !== 5'h1f) begin n_fail++; $display("FAIL edge4_rise got %h exp 1f", clk_out); end
      n_tests++; if (tick !== 5'h1f) begin n_fail++; $display("FAIL edge4_tick got %h exp 1f", tick); end
      step(1);
      n_tests++; if (tick !== 5'h00) begin n_fail++; $display("FAIL edge5_tick got %h exp 00", tick); end
      step(2);
      n_tests++; if (clk_out !== 5'h1f) begin n_fail++; $display("FAIL edge7_high got %h exp 1f", clk_out); end
      step(1);
      n_tests++; if (clk_out !== 5'h00) begin n_fail++; $display("FAIL edge8_fall got %h exp 00", clk_out); end
      step(3);
      n_tests++; if (tick !== 5'h00) begin n_fail++; $display("FAIL edge11_tick got %h exp 00", tick); end
      step(1);
      n_tests++; if (clk_out !== 5'h1f || tick !== 5'h1f) begin n_fail++; $display("FAIL edge12_rise got %h/%h exp 1f/1f", clk_out, tick); end
   endtask

   // ch1 at L=3; write L=1 during its high phase
   task automatic test_write_mid_high();
      pulse_sync();                         // S
      step(4);                              // S+4: rise
      n_tests++; if (clk_out[1] !== 1'b1) begin n_fail++; $display("FAIL wmh_rise got %b exp 1", clk_out[1]); end
      do_write(1, 1, 1);                    // S+5
      n_tests++; if (pending[1] !== 1'b1) begin n_fail++; $display("FAIL wmh_pend_set got %b exp 1", pending[1]); end
      step(2);                              // S+7
      n_tests++; if (clk_out[1] !== 1'b1 || pending[1] !== 1'b1) begin n_fail++; $display("FAIL wmh_old_high got %b/%b exp 1/1", clk_out[1], pending[1]); end
      step(1);                              // S+8
      n_tests++; if (clk_out[1] !== 1'b0 || pending[1] !== 1'b0) begin n_fail++; $display("FAIL wmh_apply got %b/%b exp 0/0", clk_out[1], pending[1]); end
      step(1);                              // S+9
      n_tests++; if (clk_out[1] !== 1'b0) begin n_fail++; $display("FAIL wmh_new_low got %b exp 0", clk_out[1]); end
      step(1);                              // S+10
      n_tests++; if (clk_out[1] !== 1'b1 || tick[1] !== 1'b1) begin n_fail++; $display("FAIL wmh_new_rise got %b/%b exp 1/1", clk_out[1], tick[1]); end
      step(2);                              // S+12
      n_tests++; if (clk_out[1] !== 1'b0) begin n_fail++; $display("FAIL wmh_new_fall got %b exp 0", clk_out[1]); end
   endtask

   // ch2: writes 5 then 2 before the apply point
   task automatic test_last_write_wins();
      pulse_sync();                         // S
      do_write(2, 5, 5);                    // S+1
      do_write(2, 2, 2);                    // S+2
      n_tests++; if (pending[2] !== 1'b1) begin n_fail++; $display("FAIL lww_pend got %b exp 1", pending[2]); end
      step(6);                              // S+8: old period ends
      n_tests++; if (clk_out[2] !== 1'b0 || pending[2] !== 1'b0) begin n_fail++; $display("FAIL lww_apply got %b/%b exp 0/0", clk_out[2], pending[2]); end
      step(2);                              // S+10
      n_tests++; if (clk_out[2] !== 1'b0) begin n_fail++; $display("FAIL lww_low got %b exp 0", clk_out[2]); end
      step(1);                              // S+11
      n_tests++; if (clk_out[2] !== 1'b1 || tick[2] !== 1'b1) begin n_fail++; $display("FAIL lww_rise got %b/%b exp 1/1", clk_out[2], tick[2]); end
      step(2);                              // S+13
      n_tests++; if (clk_out[2] !== 1'b1) begin n_fail++; $display("FAIL lww_high got %b exp 1", clk_out[2]); end
      step(1);                              // S+14
      n_tests++; if (clk_out[2] !== 1'b0) begin n_fail++; $display("FAIL lww_fall got %b exp 0", clk_out[2]); end
   endtask

   // ch2 L=2, ch3 L=5 applied by sync; ch4 written in the same cycle as sync
   task automatic test_sync();
      do_write(3, 5, 5);
      do_write(4, 1, 1);
      wr_valid = 1'b1; wr_ch = 3'd4; wr_low = 8'd0; wr_high = 8'd0; sync = 1'b1;
      step(1);                              // S
      wr_valid = 1'b0; sync = 1'b0;
      n_tests++; if (clk_out !== 5'h00 || tick !== 5'h00) begin n_fail++; $display("FAIL sync_clear got %h/%h exp 00/00", clk_out, tick); end
      n_tests++; if (pending !== 5'h10) begin n_fail++; $display("FAIL sync_pending got %h exp 10", pending); end
      step(2);                              // S+2
      n_tests++; if (clk_out[4] !== 1'b1) begin n_fail++; $display("FAIL sync_ch4_rise got %b exp 1", clk_out[4]); end
      step(1);                              // S+3
      n_tests++; if (clk_out[2] !== 1'b1 || tick[2] !== 1'b1 || clk_out[3] !== 1'b0) begin n_fail++; $display("FAIL sync_ch2_rise got %b/%b/%b exp 1/1/0", clk_out[2], tick[2], clk_out[3]); end
      step(1);                              // S+4
      n_tests++; if (clk_out[4] !== 1'b0 || pending[4] !== 1'b0) begin n_fail++; $display("FAIL sync_ch4_apply got %b/%b exp 0/0", clk_out[4], pending[4]); end
      step(1);                              // S+5
      n_tests++; if (clk_out[4] !== 1'b1 || clk_out[3] !== 1'b0) begin n_fail++; $display("FAIL sync_ch4_l0 got %b/%b exp 1/0", clk_out[4], clk_out[3]); end
      step(1);                              // S+6
      n_tests++; if (clk_out[3] !== 1'b1 || tick[3] !== 1'b1 || clk_out[2] !== 1'b0) begin n_fail++; $display("FAIL sync_ch3_rise got %b/%b/%b exp 1/1/0", clk_out[3], tick[3], clk_out[2]); end
   endtask

   // ch0 wr_low=2 wr_high=0
   task automatic test_duty();
      logic exp4, exp7, exp9;
`ifdef CLKDIV_DUTY_EN
      exp4 = 1'b0; exp7 = 1'b1; exp9 = 1'b0;
`else
      exp4 = 1'b1; exp7 = 1'b0; exp9 = 1'b1;
`endif
      do_write(0, 2, 0);
      pulse_sync();                         // S
      step(3);                              // S+3
      n_tests++; if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin n_fail++; $display("FAIL duty_rise got %b/%b exp 1/1", clk_out[0], tick[0]); end
      step(1);                              // S+4
      n_tests++; if (clk_out[0] !== exp4) begin n_fail++; $display("FAIL duty_s4 got %b exp %b", clk_out[0], exp4); end
      step(2);                              // S+6
      n_tests++; if (clk_out[0] !== 1'b0) begin n_fail++; $display("FAIL duty_s6 got %b exp 0", clk_out[0]); end
      step(1);                              // S+7
      n_tests++; if (clk_out[0] !== exp7) begin n_fail++; $display("FAIL duty_s7 got %b exp %b", clk_out[0], exp7); end
      step(2);                              // S+9
      n_tests++; if (clk_out[0] !== exp9) begin n_fail++; $display("FAIL duty_s9 got %b exp %b", clk_out[0], exp9); end
   endtask

   task automatic test_disable_reset();
      en = 5'b10111;
      step(1);
      n_tests++; if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin n_fail++; $display("FAIL dis_hold got %b/%b exp 0/0", clk_out[3], tick[3]); end
      do_write(3, 1, 1);
      n_tests++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL dis_wr_pend got %b exp 1", pending[3]); end
      step(1);
      n_tests++; if (pending[3] !== 1'b0) begin n_fail++; $display("FAIL dis_apply got %b exp 0", pending[3]); end
      do_write(CH, 0, 0);
      n_tests++; if (pending !== 5'h00) begin n_fail++; $display("FAIL oor_write got %h exp 00", pending); end
      step(3);
      n_tests++; if (clk_out[3] !== 1'b0) begin n_fail++; $display("FAIL dis_still_low got %b exp 0", clk_out[3]); end
      pulse_sync();                         // S
      do_write(1, 7, 7);                    // S+1
      step(2);                              // S+3
      n_tests++; if (clk_out[0] !== 1'b1 || pending[1] !== 1'b1) begin n_fail++; $display("FAIL pre_ar got %b/%b exp 1/1", clk_out[0], pending[1]); end
      #3 ar = 1'b1;
      #1;
      n_tests++; if (clk_out !== 5'h00 || tick !== 5'h00) begin n_fail++; $display("FAIL async_ar got %h/%h exp 00/00", clk_out, tick); end
      n_tests++; if (pending !== 5'h00 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL async_ar_pend got %h/%b exp 00/0", pending, wr_ready); end
      step(2);
      ar = 1'b0;
      en = '1;
   endtask

   initial begin
      test_reset();
      test_write_mid_high();
      test_last_write_wins();
      test_sync();
      test_duty();
      test_disable_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
